// File: rtl/id_control_unit.sv
// id_control_unit: RV32IM decode stage with ID/EX pipeline register.
//   Decodes one instruction per cycle into the ALU SELECT code, the operand
//   mux selects, the memory and writeback controls, and a sign-extended
//   immediate. The result is captured into the ID/EX register, which has
//   stall and flush controls.
// Ports:
//   CLK, RESET (sync, active high)
//   INSTR_IN, PC_IN, VALID_IN   : instruction from the IF/ID register
//   STALL, FLUSH                : hazard-unit controls for the ID/EX register
//   VALID_OUT, PC_OUT, ALUOP, OP1SEL, OP2SEL, IMM, RS1, RS2, RD,
//   REG_WRITE, MEM_READ, MEM_WRITE, FUNCT3_OUT, BRANCH, JUMP, WB_SEL,
//   ILLEGAL                     : registered decode results
module id_control_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR_IN,
  input  logic [31:0] PC_IN,
  input  logic        VALID_IN,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        VALID_OUT,
  output logic [31:0] PC_OUT,
  output logic [4:0]  ALUOP,
  output logic        OP1SEL,
  output logic        OP2SEL,
  output logic [31:0] IMM,
  output logic [4:0]  RS1,
  output logic [4:0]  RS2,
  output logic [4:0]  RD,
  output logic        REG_WRITE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [2:0]  FUNCT3_OUT,
  output logic        BRANCH,
  output logic        JUMP,
  output logic [1:0]  WB_SEL,
  output logic        ILLEGAL
);

  localparam logic [4:0] ALU_FWD = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2,
                         ALU_SRA = 5'd8, ALU_MUL = 5'd11;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  aluop;
    logic        op1sel;
    logic        op2sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic [1:0]  wb_sel;
    logic        illegal;
  } idex_t;

  // Base integer op selected by funct3 (shared by OP and OP-IMM).
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = 5'd1;  // ADD
      3'b001:  alu_base = 5'd3;  // SLL
      3'b010:  alu_base = 5'd4;  // SLT
      3'b011:  alu_base = 5'd5;  // SLTU
      3'b100:  alu_base = 5'd6;  // XOR
      3'b101:  alu_base = 5'd7;  // SRL
      3'b110:  alu_base = 5'd9;  // OR
      default: alu_base = 5'd10; // AND
    endcase
  endfunction

  function automatic idex_t decode(input logic [31:0] i, input logic [31:0] pc);
    idex_t      d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    d = '0;
    d.valid  = 1'b1;
    d.pc     = pc;
    d.aluop  = ALU_ADD;
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    d.rd     = i[11:7];
    d.funct3 = f3;
    case (i[6:0])
      7'b0110111: begin // LUI
        d.aluop = ALU_FWD; d.op2sel = 1'b1; d.imm = {i[31:12], 12'b0}; d.reg_write = 1'b1;
      end
      7'b0010111: begin // AUIPC
        d.op1sel = 1'b1; d.op2sel = 1'b1; d.imm = {i[31:12], 12'b0}; d.reg_write = 1'b1;
      end
      7'b1101111: begin // JAL
        d.op1sel = 1'b1; d.op2sel = 1'b1;
        d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        d.jump = 1'b1; d.wb_sel = 2'd2; d.reg_write = 1'b1;
      end
      7'b1100111: begin // JALR
        d.op2sel = 1'b1; d.imm = {{20{i[31]}}, i[31:20]};
        d.jump = 1'b1; d.wb_sel = 2'd2; d.reg_write = 1'b1;
      end
      7'b1100011: begin // BRANCH
        d.aluop = ALU_SUB; d.branch = 1'b1;
        d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011) d.illegal = 1'b1;
      end
      7'b0000011: begin // LOAD
        d.op2sel = 1'b1; d.imm = {{20{i[31]}}, i[31:20]};
        d.mem_read = 1'b1; d.wb_sel = 2'd1; d.reg_write = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d.illegal = 1'b1;
      end
      7'b0100011: begin // STORE
        d.op2sel = 1'b1; d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; d.mem_write = 1'b1;
        if (f3 >= 3'b011) d.illegal = 1'b1;
      end
      7'b0010011: begin // OP-IMM
        d.aluop = alu_base(f3); d.op2sel = 1'b1; d.reg_write = 1'b1;
        d.imm = {{20{i[31]}}, i[31:20]};
        // Shifts carry only the shamt; funct7 must be a legal shift encoding.
        if (f3 == 3'b001) begin
          d.imm = {27'b0, i[24:20]};
          if (f7 != 7'b0000000) d.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          d.imm = {27'b0, i[24:20]};
          if (f7 == 7'b0100000) d.aluop = ALU_SRA;
          else if (f7 != 7'b0000000) d.illegal = 1'b1;
        end
      end
      7'b0110011: begin // OP
        d.reg_write = 1'b1;
        case (f7)
          7'b0000000: d.aluop = alu_base(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      d.aluop = ALU_SUB;
            else if (f3 == 3'b101) d.aluop = ALU_SRA;
            else                   d.illegal = 1'b1;
          end
          7'b0000001: d.aluop = ALU_MUL + {2'b0, f3};
          default:    d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    // Illegal instructions still flow down the pipe but must not change state.
    if (d.illegal) begin
      d.reg_write = 1'b0; d.mem_read = 1'b0; d.mem_write = 1'b0;
      d.branch = 1'b0; d.jump = 1'b0;
    end
    return d;
  endfunction

  // Bubble: decoded NOP with every control bit cleared and valid dropped.
  function automatic idex_t bubble(input logic [31:0] pc);
    idex_t b;
    b = decode(NOP_INSTR, pc);
    b.valid = 1'b0; b.op1sel = 1'b0; b.op2sel = 1'b0; b.reg_write = 1'b0;
    b.mem_read = 1'b0; b.mem_write = 1'b0; b.branch = 1'b0; b.jump = 1'b0;
    b.wb_sel = 2'd0; b.illegal = 1'b0;
    return b;
  endfunction

  idex_t dec, q;

  always_comb begin
    dec = VALID_IN ? decode(INSTR_IN, PC_IN) : bubble(PC_IN);
  end

  always_ff @(posedge CLK) begin
    if (RESET)       q <= bubble(32'h0);
    else if (FLUSH)  q <= bubble(PC_IN);
    else if (!STALL) q <= dec;
  end

  assign VALID_OUT  = q.valid;
  assign PC_OUT     = q.pc;
  assign ALUOP      = q.aluop;
  assign OP1SEL     = q.op1sel;
  assign OP2SEL     = q.op2sel;
  assign IMM        = q.imm;
  assign RS1        = q.rs1;
  assign RS2        = q.rs2;
  assign RD         = q.rd;
  assign REG_WRITE  = q.reg_write;
  assign MEM_READ   = q.mem_read;
  assign MEM_WRITE  = q.mem_write;
  assign FUNCT3_OUT = q.funct3;
  assign BRANCH     = q.branch;
  assign JUMP       = q.jump;
  assign WB_SEL     = q.wb_sel;
  assign ILLEGAL    = q.illegal;

endmodule

// File: tb/tb_id_control_unit.sv
// tb_id_control_unit: self-checking bench for id_control_unit.
//   Expected ID/EX contents are pushed to a queue as each cycle's stimulus is
//   driven and popped when the registered outputs are sampled after the edge.
module tb_id_control_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0, VALID_IN = 1'b0, STALL = 1'b0, FLUSH = 1'b0;
  logic [31:0] INSTR_IN = '0, PC_IN = '0;
  logic        VALID_OUT, OP1SEL, OP2SEL, REG_WRITE, MEM_READ, MEM_WRITE;
  logic        BRANCH, JUMP, ILLEGAL;
  logic [31:0] PC_OUT, IMM;
  logic [4:0]  ALUOP, RS1, RS2, RD;
  logic [2:0]  FUNCT3_OUT;
  logic [1:0]  WB_SEL;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  aluop;
    logic        op1sel, op2sel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw;
    logic [2:0]  f3;
    logic        br, jmp;
    logic [1:0]  wb;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  id_control_unit dut (
    .CLK(CLK), .RESET(RESET), .INSTR_IN(INSTR_IN), .PC_IN(PC_IN),
    .VALID_IN(VALID_IN), .STALL(STALL), .FLUSH(FLUSH),
    .VALID_OUT(VALID_OUT), .PC_OUT(PC_OUT), .ALUOP(ALUOP), .OP1SEL(OP1SEL),
    .OP2SEL(OP2SEL), .IMM(IMM), .RS1(RS1), .RS2(RS2), .RD(RD),
    .REG_WRITE(REG_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNCT3_OUT(FUNCT3_OUT), .BRANCH(BRANCH), .JUMP(JUMP), .WB_SEL(WB_SEL),
    .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic exp_t mk(
    input logic v, input logic [31:0] pc, input logic [4:0] alu,
    input logic o1, input logic o2, input logic [31:0] imm,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
    input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
    input logic br, input logic j, input logic [1:0] wb, input logic il);
    return '{v, pc, alu, o1, o2, imm, r1, r2, rd, rw, mr, mw, f3, br, j, wb, il};
  endfunction

  function automatic exp_t bub(input logic [31:0] pc);
    return mk(0, pc, 5'd1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0);
  endfunction

  function automatic exp_t got();
    return {VALID_OUT, PC_OUT, ALUOP, OP1SEL, OP2SEL, IMM, RS1, RS2, RD,
            REG_WRITE, MEM_READ, MEM_WRITE, FUNCT3_OUT, BRANCH, JUMP, WB_SEL, ILLEGAL};
  endfunction

  // Drive one cycle of stimulus, record its expectation, then move to the
  // sample point just after the capturing edge.
  task automatic apply(input logic [31:0] instr, input logic [31:0] pc,
                       input logic vin, input logic rst, input logic stall,
                       input logic flush, input exp_t e);
    @(negedge CLK);
    INSTR_IN = instr; PC_IN = pc; VALID_IN = vin;
    RESET = rst; STALL = stall; FLUSH = flush;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      apply(32'h00500093, 32'h55, 1, 1, 0, 0, bub(32'h0));
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL reset[%0d] got %h exp %h", i, got(), e);
      end
    end
  endtask

  task automatic test_decode;
    logic [31:0] ins [10];
    logic [31:0] pcs [10];
    exp_t        ex  [10];
    exp_t        e;
    ins[0] = 32'h00500093; pcs[0] = 32'h10;  // addi x1,x0,5
    ex[0]  = mk(1, 32'h10, 1, 0, 1, 32'h5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    ins[1] = 32'h402081B3; pcs[1] = 32'h14;  // sub x3,x1,x2
    ex[1]  = mk(1, 32'h14, 2, 0, 0, 32'h0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    ins[2] = 32'h027332B3; pcs[2] = 32'h18;  // mulhu x5,x6,x7
    ex[2]  = mk(1, 32'h18, 14, 0, 0, 32'h0, 6, 7, 5, 1, 0, 0, 3, 0, 0, 0, 0);
    ins[3] = 32'hFE208CE3; pcs[3] = 32'h100; // beq x1,x2,-8
    ex[3]  = mk(1, 32'h100, 2, 0, 0, 32'hFFFFFFF8, 1, 2, 25, 0, 0, 0, 0, 1, 0, 0, 0);
    ins[4] = 32'h123450B7; pcs[4] = 32'h104; // lui x1,0x12345
    ex[4]  = mk(1, 32'h104, 0, 0, 1, 32'h12345000, 8, 3, 1, 1, 0, 0, 5, 0, 0, 0, 0);
    ins[5] = 32'h008000EF; pcs[5] = 32'h108; // jal x1,+8
    ex[5]  = mk(1, 32'h108, 1, 1, 1, 32'h8, 0, 8, 1, 1, 0, 0, 0, 0, 1, 2, 0);
    ins[6] = 32'h0040A103; pcs[6] = 32'h10C; // lw x2,4(x1)
    ex[6]  = mk(1, 32'h10C, 1, 0, 1, 32'h4, 1, 4, 2, 1, 1, 0, 2, 0, 0, 1, 0);
    ins[7] = 32'h0020A423; pcs[7] = 32'h110; // sw x2,8(x1)
    ex[7]  = mk(1, 32'h110, 1, 0, 1, 32'h8, 1, 2, 8, 0, 0, 1, 2, 0, 0, 0, 0);
    ins[8] = 32'h4030D093; pcs[8] = 32'h114; // srai x1,x1,3
    ex[8]  = mk(1, 32'h114, 8, 0, 1, 32'h3, 1, 3, 1, 1, 0, 0, 5, 0, 0, 0, 0);
    ins[9] = 32'h00001297; pcs[9] = 32'h118; // auipc x5,1
    ex[9]  = mk(1, 32'h118, 1, 1, 1, 32'h1000, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 0);
    // Issued back to back: one new instruction per cycle.
    for (int i = 0; i < 10; i++) begin
      apply(ins[i], pcs[i], 1, 0, 0, 0, ex[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL decode[%0d] instr %h got %h exp %h", i, ins[i], got(), e);
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ins [6];
    logic        vin [6];
    exp_t        ex  [6];
    exp_t        e;
    ins[0] = 32'hFFFFFFFF; vin[0] = 1;
    ex[0]  = mk(1, 32'h200, 1, 0, 0, 32'h0, 31, 31, 31, 0, 0, 0, 7, 0, 0, 0, 1);
    ins[1] = 32'h00100013; vin[1] = 1;       // addi x0,x0,1: no write to x0
    ex[1]  = mk(1, 32'h204, 1, 0, 1, 32'h1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ins[2] = 32'h02109093; vin[2] = 1;       // slli with funct7=0000001
    ex[2]  = mk(1, 32'h208, 3, 0, 1, 32'h1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    ins[3] = 32'h0020A063; vin[3] = 1;       // branch funct3=010
    ex[3]  = mk(1, 32'h20C, 2, 0, 0, 32'h0, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 1);
    ins[4] = 32'h0040B103; vin[4] = 1;       // load funct3=011
    ex[4]  = mk(1, 32'h210, 1, 0, 1, 32'h4, 1, 4, 2, 0, 0, 0, 3, 0, 0, 1, 1);
    ins[5] = 32'h00500093; vin[5] = 0;       // not a real instruction
    ex[5]  = bub(32'h214);
    for (int i = 0; i < 6; i++) begin
      apply(ins[i], 32'h200 + 32'(4 * i), vin[i], 0, 0, 0, ex[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL illegal[%0d] instr %h got %h exp %h", i, ins[i], got(), e);
      end
    end
  endtask

  task automatic test_stall_flush;
    exp_t addi_e, e;
    addi_e = mk(1, 32'h10, 1, 0, 1, 32'h5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(32'h00500093, 32'h10, 1, 0, 0, 0, addi_e);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(32'h402081B3, 32'h40 + 32'(i), 1, 0, 1, 0, addi_e);
      else       apply(32'h402081B3, 32'h44, 1, 0, 1, 1, bub(32'h44));
      // Drain the load cycle's entry on the first pass.
      if (i == 0) begin
        e = sb.pop_front();
        checks++;
        if (e !== addi_e || got() !== e) begin
          errors++;
          $display("FAIL stall_load got %h exp %h", got(), addi_e);
        end
      end
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL stall[%0d] got %h exp %h", i, got(), e);
      end
    end
    // Plain flush over a valid instruction, then normal flow resumes.
    apply(32'h027332B3, 32'h48, 1, 0, 0, 1, bub(32'h48));
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      errors++;
      $display("FAIL flush got %h exp %h", got(), e);
    end
    apply(32'h027332B3, 32'h4C, 1, 0, 0, 0,
          mk(1, 32'h4C, 14, 0, 0, 32'h0, 6, 7, 5, 1, 0, 0, 3, 0, 0, 0, 0));
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      errors++;
      $display("FAIL resume got %h exp %h", got(), e);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_stall_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
